// File: rtl/sum_uart_tx.sv
// Change-filtered sum logger: queues each new distinct sum in a small FIFO and sends it as UART.
// Define SUM_UART_PARITY_EN to append an even parity bit (8E1 framing instead of 8N1).
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               sum_in,
  input  logic                     sum_valid,
  input  logic                     clr_overflow,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef SUM_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t         state_reg;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [LW-1:0]  count_reg;
  logic [7:0]     last_reg;
  logic           last_valid_reg;
  logic           overflow_reg;
  logic [7:0]     shift_reg;
  logic [CW-1:0]  baud_reg;
  logic [2:0]     bit_reg;
  logic           tx_reg;
  logic           busy_reg;
`ifdef SUM_UART_PARITY_EN
  logic           parity_reg;
`endif

  logic is_new;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic baud_done;

  assign is_new    = sum_valid && ena && (!last_valid_reg || (sum_in != last_reg));
  assign full      = (count_reg == LW'(DEPTH));
  assign pop       = (state_reg == IDLE) && (count_reg != '0);
  // A pop on the same edge frees the slot the push needs
  assign push      = is_new && (!full || pop);
  assign drop      = is_new && full && !pop;
  assign baud_done = (baud_reg == CW'(CLKS_PER_BIT - 1));

  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign fifo_level = count_reg;
  assign overflow   = overflow_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= sum_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      last_reg       <= '0;
      last_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg     <= wr_ptr_reg + 1'b1;
        last_reg       <= sum_in;
        last_valid_reg <= 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      baud_reg   <= '0;
      bit_reg    <= '0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
`ifdef SUM_UART_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            shift_reg  <= mem[rd_ptr_reg];
`ifdef SUM_UART_PARITY_EN
            parity_reg <= ^mem[rd_ptr_reg];
`endif
            tx_reg     <= 1'b0;
            busy_reg   <= 1'b1;
            baud_reg   <= '0;
            bit_reg    <= '0;
            state_reg  <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_reg  <= '0;
            tx_reg    <= shift_reg[0];
            state_reg <= DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (bit_reg == 3'd7) begin
`ifdef SUM_UART_PARITY_EN
              tx_reg    <= parity_reg;
              state_reg <= PARITY;
`else
              tx_reg    <= 1'b1;
              state_reg <= STOP;
`endif
            end else begin
              bit_reg   <= bit_reg + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx_reg    <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`ifdef SUM_UART_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_reg  <= '0;
            tx_reg    <= 1'b1;
            state_reg <= STOP;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud_reg  <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx: per-cycle reference model, directed frame captures, vector table, random traffic.
module tb_sum_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef SUM_UART_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic [7:0]    sum_in;
  logic          sum_valid;
  logic          clr_overflow;
  logic          tx;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  sum_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sum_in(sum_in), .sum_valid(sum_valid),
    .clr_overflow(clr_overflow), .tx(tx), .busy(busy), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of accepted values plus a count of cycles left in the current frame
  logic [7:0] mq[$];
  int         m_left;
  logic       m_ovf;
  logic [7:0] m_last;
  bit         m_fv;
  logic [7:0] m_cur;
  bit         m_pop, m_new, m_full;

  function automatic logic frame_bit(logic [7:0] d, int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef SUM_UART_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_left = 0;
      m_ovf  = 1'b0;
      m_fv   = 1'b0;
      m_last = '0;
      m_cur  = '0;
    end else begin
      m_pop  = (m_left == 0) && (mq.size() > 0);
      m_new  = sum_valid && ena && (!m_fv || sum_in != m_last);
      m_full = (mq.size() >= DEPTH);
      if (m_left > 0) m_left--;
      if (m_pop) begin
        m_cur  = mq.pop_front();
        m_left = FRAME * CPB;
      end
      if (m_new && (!m_full || m_pop)) begin
        mq.push_back(sum_in);
        m_last = sum_in;
        m_fv   = 1'b1;
      end else if (m_new) begin
        m_ovf = 1'b1;
      end else if (clr_overflow) begin
        m_ovf = 1'b0;
      end
      if (m_new && !(m_full && !m_pop) && clr_overflow) m_ovf = 1'b0;
    end
  end

  bit chk_en = 1'b0;
  int frames_seen = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tx", tx, (m_left == 0) ? 1'b1 : frame_bit(m_cur, (FRAME*CPB - m_left) / CPB));
      check("model_busy", busy, m_left > 0);
      check("model_level", fifo_level, mq.size());
      check("model_overflow", overflow, m_ovf);
      if (busy === 1'b1 && prev_busy !== 1'b1) frames_seen++;
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && fifo_level === '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_within_bound", ok, 1'b1);
  endtask

  // Called at a negedge; pushes d and records each bit slot plus the busy cycle count
  task automatic send_capture(input logic [7:0] d, output logic [10:0] bits, output int bcyc);
    bits = '1;
    bcyc = 0;
    sum_in = d;
    sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
    check("tx_high_after_push_edge", tx, 1'b1);
    bcyc += int'(busy);
    for (int k = 0; k < FRAME*CPB + 4; k++) begin
      @(negedge clk);
      bcyc += int'(busy);
      if ((k % CPB) == 1 && (k / CPB) < FRAME) bits[k/CPB] = tx;
    end
  endtask

  typedef struct {
    logic          v;
    logic [7:0]    d;
    logic          en;
    logic          clr;
    logic [LW-1:0] lvl;
    logic          ovf;
    int            frames;
  } vec_t;

  vec_t vecs[15];
  logic [10:0] bits;
  logic [10:0] exp_bits;
  int bcyc;
  int mark;
  logic [7:0] d0;

  initial begin
    rst_n = 1'b1;
    ena = 1'b1;
    sum_in = '0;
    sum_valid = 1'b0;
    clr_overflow = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Reset held, then released: idle line and no spontaneous frames
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, '0);
    check("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_frame_after_reset", frames_seen, 0);
    check("idle_tx", tx, 1'b1);

    // 0xA5 frame shape and busy width
    send_capture(8'hA5, bits, bcyc);
`ifdef SUM_UART_PARITY_EN
    exp_bits = 11'b1_0_10100101_0;
`else
    exp_bits = 11'b1_1_10100101_0;
`endif
    check("frame_a5_bits", bits, exp_bits);
    check("frame_a5_busy_cycles", bcyc, FRAME*CPB);

`ifdef SUM_UART_PARITY_EN
    send_capture(8'h07, bits, bcyc);
    exp_bits = 11'b1_1_00000111_0;
    check("frame_07_parity", bits, exp_bits);
    check("frame_07_busy_cycles", bcyc, 11*CPB);
    send_capture(8'h03, bits, bcyc);
    exp_bits = 11'b1_0_00000011_0;
    check("frame_03_parity", bits, exp_bits);
`endif
    wait_idle();

    //          v     d      en    clr   lvl ovf frames
    vecs[0]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 0, -1};
    vecs[1]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 0, 0, -1};
    vecs[2]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 0, 0, -1};
    vecs[3]  = '{1'b1, 8'h42, 1'b1, 1'b0, 1, 0,  2};
    vecs[4]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 0, -1};
    vecs[5]  = '{1'b1, 8'h12, 1'b1, 1'b0, 1, 0, -1};
    vecs[6]  = '{1'b1, 8'h13, 1'b1, 1'b0, 2, 0, -1};
    vecs[7]  = '{1'b1, 8'h14, 1'b1, 1'b0, 3, 0, -1};
    vecs[8]  = '{1'b1, 8'h15, 1'b1, 1'b0, 4, 0, -1};
    vecs[9]  = '{1'b1, 8'h16, 1'b1, 1'b0, 4, 1,  5};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 0, -1};
    vecs[11] = '{1'b1, 8'h15, 1'b1, 1'b0, 0, 0, -1};
    vecs[12] = '{1'b1, 8'h16, 1'b1, 1'b0, 1, 0,  1};
    vecs[13] = '{1'b1, 8'h77, 1'b0, 1'b0, 0, 0,  0};
    vecs[14] = '{1'b1, 8'h77, 1'b1, 1'b1, 1, 0,  1};

    mark = frames_seen;
    for (int i = 0; i < 15; i++) begin
      sum_valid = vecs[i].v;
      sum_in = vecs[i].d;
      ena = vecs[i].en;
      clr_overflow = vecs[i].clr;
      @(negedge clk);
      sum_valid = 1'b0;
      clr_overflow = 1'b0;
      ena = 1'b1;
      check($sformatf("vec%0d_level", i), fifo_level, vecs[i].lvl);
      check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
      if (vecs[i].frames >= 0) begin
        wait_idle();
        check($sformatf("vec%0d_frames", i), frames_seen - mark, vecs[i].frames);
        mark = frames_seen;
      end
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sum_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: sum_in = 8'h00;
        1: sum_in = 8'hFF;
        2: sum_in = 8'h5A;
        default: sum_in = 8'($urandom);
      endcase
      ena = ($urandom_range(0, 7) != 0);
      clr_overflow = ($urandom_range(0, 40) == 0);
      @(negedge clk);
    end
    sum_valid = 1'b0;
    ena = 1'b1;
    clr_overflow = 1'b0;
    wait_idle();

    // Reset mid-DATA with two entries queued
    d0 = m_last + 8'd1;
    for (int i = 0; i < 3; i++) begin
      sum_in = d0 + 8'(i);
      sum_valid = 1'b1;
      @(negedge clk);
    end
    sum_valid = 1'b0;
    check("midframe_level", fifo_level, 2);
    repeat (2*CPB) @(negedge clk);
    check("midframe_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_level", fifo_level, '0);
    check("async_rst_overflow", overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mark = frames_seen;
    repeat (100) @(negedge clk);
    check("no_frames_after_midframe_reset", frames_seen - mark, 0);
    check("tx_idle_after_midframe_reset", tx, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
